draw_sprite_layer: RTL and testbench

Parametrised successor to the fixed-size bug/sprite drawing stage in the VGA pixel pipeline. It sits between draw_background and the mouse overlay, or can be chained for multiple layers. It overlays one ROM-backed sprite of configurable size at a frame-latched position, adding:
- colour-key transparency
- horizontal mirror
- 2x integer scaling
- configurable ROM read latency
All timing signals are delay-matched to the pixel data.

---
 rtl/vga_pkg.sv | 41 ++++
 rtl/vga_delay.sv | 36 +++
 rtl/draw_sprite_layer.sv | 184 ++++++++++++++++++
 tb/tb_draw_sprite_layer.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA pipeline types: 12-bit counts and colours, the timing bundle,
// and the per-pixel record that travels down a sprite layer's delay line.
package vga_pkg;

   localparam int CNT_W = 12;
   localparam int RGB_W = 12;

   typedef logic [RGB_W-1:0] rgb_t;
   typedef logic [CNT_W-1:0] cnt_t;

   typedef struct packed {
      cnt_t hcount;
      logic hsync;
      logic hblnk;
      cnt_t vcount;
      logic vsync;
      logic vblnk;
   } vga_timing_t;

   // Sprite placement captured once per frame at the start of vertical blanking
   typedef struct packed {
      cnt_t x;
      cnt_t y;
      logic en;
      logic mir;
      logic sc;
   } sprite_shadow_t;

   typedef struct packed {
      vga_timing_t timing;
      rgb_t        rgb;
      logic        in_box;
   } pix_stage_t;

   localparam rgb_t DEFAULT_KEY_COLOR = 12'h0F0;

   function automatic logic is_blanked(input vga_timing_t t);
      return t.hblnk | t.vblnk;
   endfunction

endpackage

// File: rtl/vga_delay.sv
// Fixed-depth register pipeline with asynchronous active-low clear, used to
// keep timing and upstream pixel data aligned with a ROM read.
module vga_delay #(
   parameter int DEPTH = 1,
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [DEPTH-1:0][WIDTH-1:0] stage_q;
   logic [DEPTH-1:0][WIDTH-1:0] stage_d;

   // Shift every stage one step further down the line
   always_comb begin
      stage_d    = stage_q;
      stage_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   // Pipeline registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/draw_sprite_layer.sv
// One ROM-backed sprite layer: frame-latched position, colour-key transparency,
// horizontal mirror and 2x scaling, with timing delayed by ROM_LAT+2 cycles.
module draw_sprite_layer
   import vga_pkg::*;
#(
   parameter int   SPRITE_W  = 48,
   parameter int   SPRITE_H  = 64,
   parameter int   ADDR_W    = 12,
   parameter int   ROM_LAT   = 1,
   parameter rgb_t KEY_COLOR = DEFAULT_KEY_COLOR
) (
   input  logic              pclk,
   input  logic              rst,
   input  logic [11:0]       hcount_in,
   input  logic              hsync_in,
   input  logic              hblnk_in,
   input  logic [11:0]       vcount_in,
   input  logic              vsync_in,
   input  logic              vblnk_in,
   input  logic [11:0]       rgb_in,
   input  logic [11:0]       xpos,
   input  logic [11:0]       ypos,
   input  logic              enable,
   input  logic              mirror,
   input  logic              scale2x,
   input  logic [11:0]       rgb_pixel,
   output logic [ADDR_W-1:0] pixel_addr,
   output logic [11:0]       hcount_out,
   output logic              hsync_out,
   output logic              hblnk_out,
   output logic [11:0]       vcount_out,
   output logic              vsync_out,
   output logic              vblnk_out,
   output logic [11:0]       rgb_out,
   output logic              sprite_on
);

   // 13-bit box arithmetic so x + 2*SPRITE_W cannot wrap past 4095
   localparam logic [12:0] SPAN_W1    = 13'(SPRITE_W);
   localparam logic [12:0] SPAN_W2    = 13'(2 * SPRITE_W);
   localparam logic [12:0] SPAN_H1    = 13'(SPRITE_H);
   localparam logic [12:0] SPAN_H2    = 13'(2 * SPRITE_H);
   localparam logic [12:0] MIRROR_MAX = 13'(SPRITE_W - 1);

   generate
      if (SPRITE_W * SPRITE_H > (1 << ADDR_W)) begin : g_rom_too_small
         $error("draw_sprite_layer: SPRITE_W*SPRITE_H exceeds 2**ADDR_W");
      end
      if (ROM_LAT < 1 || ROM_LAT > 4) begin : g_bad_rom_lat
         $error("draw_sprite_layer: ROM_LAT must be 1..4");
      end
   endgenerate

   sprite_shadow_t    shadow_q, shadow_d;
   logic              vblnk_prev_q, vblnk_prev_d;
   logic [ADDR_W-1:0] pixel_addr_q, pixel_addr_d;
   vga_timing_t       timing_out_q, timing_out_d;
   rgb_t              rgb_out_q, rgb_out_d;
   logic              sprite_on_q, sprite_on_d;

   logic [12:0] hc_s, vc_s, x_s, y_s;
   logic [12:0] span_w_s, span_h_s;
   logic [12:0] dx_s, dy_s, sx_s, sy_s, col_s;
   logic [25:0] lin_s;
   logic        in_box_s;
   pix_stage_t  stage_in_s, stage_out_s;

   // Capture placement controls only on the rising edge of vblnk_in
   always_comb begin
      shadow_d     = shadow_q;
      vblnk_prev_d = vblnk_in;
      if (vblnk_in && !vblnk_prev_q) begin
         shadow_d.x   = xpos;
         shadow_d.y   = ypos;
         shadow_d.en  = enable;
         shadow_d.mir = mirror;
         shadow_d.sc  = scale2x;
      end else begin
         shadow_d = shadow_q;
      end
   end

   // Shadow registers and vblank edge detector
   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         shadow_q     <= '0;
         vblnk_prev_q <= 1'b0;
      end else begin
         shadow_q     <= shadow_d;
         vblnk_prev_q <= vblnk_prev_d;
      end
   end

   // Box test and source-pixel address for the current beam position
   always_comb begin
      hc_s     = {1'b0, hcount_in};
      vc_s     = {1'b0, vcount_in};
      x_s      = {1'b0, shadow_q.x};
      y_s      = {1'b0, shadow_q.y};
      span_w_s = shadow_q.sc ? SPAN_W2 : SPAN_W1;
      span_h_s = shadow_q.sc ? SPAN_H2 : SPAN_H1;
      in_box_s = shadow_q.en
               && (hc_s >= x_s) && (hc_s < x_s + span_w_s)
               && (vc_s >= y_s) && (vc_s < y_s + span_h_s);
      dx_s     = hc_s - x_s;
      dy_s     = vc_s - y_s;
      sx_s     = shadow_q.sc ? (dx_s >> 1) : dx_s;
      sy_s     = shadow_q.sc ? (dy_s >> 1) : dy_s;
      col_s    = shadow_q.mir ? (MIRROR_MAX - sx_s) : sx_s;
      lin_s    = 26'(sy_s) * 26'(SPRITE_W) + 26'(col_s);
      // Outside the box the ROM address is parked on its last value
      if (in_box_s) begin
         pixel_addr_d = ADDR_W'(lin_s);
      end else begin
         pixel_addr_d = pixel_addr_q;
      end
   end

   // Bundle that rides alongside the ROM read
   always_comb begin
      stage_in_s               = '0;
      stage_in_s.timing.hcount = hcount_in;
      stage_in_s.timing.hsync  = hsync_in;
      stage_in_s.timing.hblnk  = hblnk_in;
      stage_in_s.timing.vcount = vcount_in;
      stage_in_s.timing.vsync  = vsync_in;
      stage_in_s.timing.vblnk  = vblnk_in;
      stage_in_s.rgb           = rgb_in;
      stage_in_s.in_box        = in_box_s;
   end

   vga_delay #(
      .DEPTH (ROM_LAT + 1),
      .WIDTH ($bits(pix_stage_t))
   ) u_delay (
      .clk   (pclk),
      .rst_n (rst),
      .din   (stage_in_s),
      .dout  (stage_out_s)
   );

   // Compositing: blanking forces black, key colour lets upstream show through
   always_comb begin
      timing_out_d = stage_out_s.timing;
      rgb_out_d    = stage_out_s.rgb;
      sprite_on_d  = 1'b0;
      if (is_blanked(stage_out_s.timing)) begin
         rgb_out_d   = 12'h000;
         sprite_on_d = 1'b0;
      end else if (stage_out_s.in_box && (rgb_pixel != KEY_COLOR)) begin
         rgb_out_d   = rgb_pixel;
         sprite_on_d = 1'b1;
      end else begin
         rgb_out_d   = stage_out_s.rgb;
         sprite_on_d = 1'b0;
      end
   end

   // ROM address and output registers
   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         pixel_addr_q <= '0;
         timing_out_q <= '0;
         rgb_out_q    <= 12'h000;
         sprite_on_q  <= 1'b0;
      end else begin
         pixel_addr_q <= pixel_addr_d;
         timing_out_q <= timing_out_d;
         rgb_out_q    <= rgb_out_d;
         sprite_on_q  <= sprite_on_d;
      end
   end

   assign pixel_addr = pixel_addr_q;
   assign hcount_out = timing_out_q.hcount;
   assign hsync_out  = timing_out_q.hsync;
   assign hblnk_out  = timing_out_q.hblnk;
   assign vcount_out = timing_out_q.vcount;
   assign vsync_out  = timing_out_q.vsync;
   assign vblnk_out  = timing_out_q.vblnk;
   assign rgb_out    = rgb_out_q;
   assign sprite_on  = sprite_on_q;

endmodule

// File: tb/tb_draw_sprite_layer.sv
// Randomised bench for draw_sprite_layer against a frame-level behavioural
// model of placement, scaling, mirroring, colour key and pipeline delay.
module tb_draw_sprite_layer;

   localparam int          L   = 3;
   localparam logic [11:0] KEY = 12'h0F0;

   logic        pclk = 1'b0;
   logic        rst  = 1'b0;
   logic [11:0] hcount_in = '0, vcount_in = '0, rgb_in = '0, xpos = '0, ypos = '0;
   logic        hsync_in = 1'b0, hblnk_in = 1'b0, vsync_in = 1'b0, vblnk_in = 1'b0;
   logic        enable = 1'b0, mirror = 1'b0, scale2x = 1'b0;
   logic [11:0] rgb_pixel;
   logic [11:0] pixel_addr, hcount_out, vcount_out, rgb_out;
   logic        hsync_out, hblnk_out, vsync_out, vblnk_out, sprite_on;

   draw_sprite_layer dut (
      .pclk(pclk), .rst(rst),
      .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
      .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
      .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos), .enable(enable),
      .mirror(mirror), .scale2x(scale2x), .rgb_pixel(rgb_pixel),
      .pixel_addr(pixel_addr),
      .hcount_out(hcount_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
      .vcount_out(vcount_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
      .rgb_out(rgb_out), .sprite_on(sprite_on)
   );

   always #5 pclk = ~pclk;

   // Sprite ROM: one cycle of read latency, contents = address except a keyed pixel
   logic [11:0] rom_mem [4096];
   logic [11:0] rom_q;
   always @(posedge pclk) rom_q <= rom_mem[pixel_addr];
   assign rgb_pixel = rom_q;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   logic [40:0] expq [$];
   logic [40:0] exp_obs;
   logic [11:0] exp_addr;
   int m_x, m_y, m_addr;
   bit m_en, m_mir, m_sc, m_prev_vb;

   function automatic logic [40:0] obs();
      return {hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out, rgb_out, sprite_on};
   endfunction

   task automatic model_reset();
      expq.delete();
      for (int i = 0; i < L - 1; i++) expq.push_back(41'd0);
      m_x = 0; m_y = 0; m_en = 0; m_mir = 0; m_sc = 0; m_prev_vb = 0; m_addr = 0;
   endtask

   task automatic set_in(input int h, input int v, input bit hb, input bit vb, input logic [11:0] rgb);
      hcount_in = 12'(h);
      vcount_in = 12'(v);
      hblnk_in  = hb;
      vblnk_in  = vb;
      rgb_in    = rgb;
      hsync_in  = 1'($urandom);
      vsync_in  = 1'($urandom);
   endtask

   // Predict the output for the inputs now on the pins, then advance one pixel clock
   task automatic step();
      int h, v, s, sx, sy;
      bit inb, blank, hit;
      logic [11:0] d, rgb_e;
      h = int'(hcount_in);
      v = int'(vcount_in);
      s = m_sc ? 2 : 1;
      inb = m_en && h >= m_x && h < m_x + 48 * s && v >= m_y && v < m_y + 64 * s;
      if (inb) begin
         sx = (h - m_x) / s;
         sy = (v - m_y) / s;
         m_addr = sy * 48 + (m_mir ? 47 - sx : sx);
      end
      d     = rom_mem[m_addr];
      blank = hblnk_in || vblnk_in;
      hit   = !blank && inb && (d != KEY);
      rgb_e = blank ? 12'h000 : (hit ? d : rgb_in);
      expq.push_back({hcount_in, hsync_in, hblnk_in, vcount_in, vsync_in, vblnk_in, rgb_e, hit});
      if (vblnk_in && !m_prev_vb) begin
         m_x = int'(xpos); m_y = int'(ypos); m_en = enable; m_mir = mirror; m_sc = scale2x;
      end
      m_prev_vb = vblnk_in;
      @(posedge pclk);
      #1;
      exp_obs  = expq.pop_front();
      exp_addr = 12'(m_addr);
   endtask

   // Start a new frame with the given placement, then scramble the live controls
   task automatic latch(input int x, input int y, input bit en, input bit mir, input bit sc);
      set_in(0, 790, 1'b1, 1'b0, 12'h000);
      step();
      xpos = 12'(x); ypos = 12'(y); enable = en; mirror = mir; scale2x = sc;
      set_in(0, 800, 1'b1, 1'b1, 12'h000);
      step();
      xpos = 12'($urandom); ypos = 12'($urandom);
      enable = 1'($urandom); mirror = 1'($urandom); scale2x = 1'($urandom);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_in(int'($urandom_range(0, 1023)), int'($urandom_range(0, 767)), 1'b0, 1'b0, 12'($urandom));
         xpos = 12'($urandom); enable = 1'b1;
         @(posedge pclk);
         #1;
      end
      n_tests++;
      if (obs() !== 41'd0 || pixel_addr !== 12'd0) begin
         $display("FAIL reset_hold out=%h addr=%h required 0", obs(), pixel_addr); n_fail++;
      end
      rst = 1'b1;
      model_reset();
      for (int i = 0; i < L + 2; i++) begin
         set_in(5 + i, 5, 1'b0, 1'b0, (i == 0) ? 12'h123 : 12'($urandom));
         step();
         n_tests++;
         if (obs() !== exp_obs) begin
            $display("FAIL reset_release i=%0d got=%h exp=%h", i, obs(), exp_obs); n_fail++;
         end
         if (i == L - 1) begin
            n_tests++;
            if (rgb_out !== 12'h123) begin
               $display("FAIL reset_first_out got=%h exp=123", rgb_out); n_fail++;
            end
         end
      end
      latch(10, 5, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         set_in(12 + i, 6, 1'b0, 1'b0, 12'($urandom));
         step();
      end
      rst = 1'b0;
      #2;
      n_tests++;
      if (obs() !== 41'd0 || pixel_addr !== 12'd0) begin
         $display("FAIL reset_async out=%h addr=%h required 0", obs(), pixel_addr); n_fail++;
      end
      @(posedge pclk);
      #1;
      rst = 1'b1;
      model_reset();
   endtask

   task automatic test_disabled();
      latch(100, 50, 1'b0, 1'b0, 1'b0);
      enable = 1'b0;
      for (int i = 0; i < 40 + L; i++) begin
         if (i < 40)
            set_in(int'($urandom_range(0, 1023)), int'($urandom_range(0, 767)),
                   $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0, 12'hABC);
         else
            set_in(0, 0, 1'b1, 1'b0, 12'hABC);
         step();
         n_tests++;
         if (obs() !== exp_obs) begin
            $display("FAIL disabled_out i=%0d got=%h exp=%h", i, obs(), exp_obs); n_fail++;
         end
         n_tests++;
         if (sprite_on !== 1'b0) begin
            $display("FAIL disabled_sprite_on i=%0d got=%b exp=0", i, sprite_on); n_fail++;
         end
      end
   endtask

   task automatic test_placement();
      int ph[$], pv[$], pa[$];
      ph = '{100, 147, 99, 148};
      pv = '{50, 113, 50, 50};
      pa = '{0, 3071, -1, -1};
      for (int k = 0; k < 16; k++) begin
         ph.push_back(int'($urandom_range(90, 160)));
         pv.push_back(int'($urandom_range(40, 125)));
         pa.push_back(-1);
      end
      latch(100, 50, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < ph.size() + L; i++) begin
         if (i < ph.size()) set_in(ph[i], pv[i], 1'b0, 1'b0, 12'($urandom));
         else set_in(0, 0, 1'b1, 1'b0, 12'h000);
         step();
         n_tests++;
         if (obs() !== exp_obs) begin
            $display("FAIL placement_out i=%0d got=%h exp=%h", i, obs(), exp_obs); n_fail++;
         end
         n_tests++;
         if (pixel_addr !== exp_addr) begin
            $display("FAIL placement_addr i=%0d got=%0d exp=%0d", i, pixel_addr, exp_addr); n_fail++;
         end
         if (i < ph.size() && pa[i] >= 0) begin
            n_tests++;
            if (pixel_addr !== 12'(pa[i])) begin
               $display("FAIL placement_addr_const i=%0d got=%0d exp=%0d", i, pixel_addr, pa[i]); n_fail++;
            end
         end
      end
   endtask

   task automatic test_transparency_mirror();
      int ph[$], pv[$], pa[$];
      for (int pass = 0; pass < 2; pass++) begin
         if (pass == 0) begin
            ph = '{105, 104, 100, 106};
            pv = '{50, 50, 55, 55};
            pa = '{5, 4, 240, 246};
         end else begin
            ph = '{100, 147, 100, 142};
            pv = '{50, 50, 51, 50};
            pa = '{47, 0, 95, 5};
         end
         latch(100, 50, 1'b1, pass == 1, 1'b0);
         for (int i = 0; i < ph.size() + L; i++) begin
            if (i < ph.size()) set_in(ph[i], pv[i], 1'b0, 1'b0, 12'($urandom));
            else set_in(0, 0, 1'b1, 1'b0, 12'h000);
            step();
            n_tests++;
            if (obs() !== exp_obs) begin
               $display("FAIL keymirror_out pass=%0d i=%0d got=%h exp=%h", pass, i, obs(), exp_obs); n_fail++;
            end
            if (i < ph.size()) begin
               n_tests++;
               if (pixel_addr !== 12'(pa[i])) begin
                  $display("FAIL keymirror_addr pass=%0d i=%0d got=%0d exp=%0d", pass, i, pixel_addr, pa[i]); n_fail++;
               end
            end
         end
      end
   endtask

   task automatic test_scale2x();
      int ph[$], pv[$], pa[$];
      ph = '{200, 201, 202, 295, 296, 200, 199};
      pv = '{0, 1, 0, 127, 0, 128, 0};
      pa = '{0, 0, 1, 3071, -1, -1, -1};
      for (int k = 0; k < 12; k++) begin
         ph.push_back(int'($urandom_range(195, 300)));
         pv.push_back(int'($urandom_range(0, 132)));
         pa.push_back(-1);
      end
      latch(200, 0, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < ph.size() + L; i++) begin
         if (i < ph.size()) set_in(ph[i], pv[i], 1'b0, 1'b0, 12'($urandom));
         else set_in(0, 0, 1'b1, 1'b0, 12'h000);
         step();
         n_tests++;
         if (obs() !== exp_obs) begin
            $display("FAIL scale2x_out i=%0d got=%h exp=%h", i, obs(), exp_obs); n_fail++;
         end
         n_tests++;
         if (pixel_addr !== exp_addr) begin
            $display("FAIL scale2x_addr i=%0d got=%0d exp=%0d", i, pixel_addr, exp_addr); n_fail++;
         end
         if (i < ph.size() && pa[i] >= 0) begin
            n_tests++;
            if (pixel_addr !== 12'(pa[i])) begin
               $display("FAIL scale2x_addr_const i=%0d got=%0d exp=%0d", i, pixel_addr, pa[i]); n_fail++;
            end
         end
      end
   endtask

   task automatic test_frame_latch_clip();
      int fx[4], fy[4];
      int ph[$], pv[$], pa[$];
      fx = '{100, 300, 1000, 4090};
      fy = '{150, 150, 50, 10};
      for (int f = 0; f < 4; f++) begin
         case (f)
            0: begin ph = '{100, 300, 147}; pv = '{200, 200, 160}; pa = '{2400, -1, 527}; end
            1: begin ph = '{300, 100, 347}; pv = '{200, 200, 213}; pa = '{2400, -1, 3071}; end
            2: begin ph = '{1000, 1023, 0, 23}; pv = '{50, 50, 50, 50}; pa = '{0, 23, -1, -1}; end
            default: begin ph = '{4095, 0, 1}; pv = '{10, 10, 10}; pa = '{5, -1, -1}; end
         endcase
         latch(fx[f], fy[f], 1'b1, 1'b0, 1'b0);
         if (f == 0) xpos = 12'd300;
         for (int i = 0; i < ph.size() + L; i++) begin
            if (i < ph.size()) set_in(ph[i], pv[i], 1'b0, 1'b0, 12'($urandom));
            else set_in(0, 0, 1'b1, 1'b0, 12'h000);
            step();
            n_tests++;
            if (obs() !== exp_obs) begin
               $display("FAIL latchclip_out f=%0d i=%0d got=%h exp=%h", f, i, obs(), exp_obs); n_fail++;
            end
            if (i < ph.size() && pa[i] >= 0) begin
               n_tests++;
               if (pixel_addr !== 12'(pa[i])) begin
                  $display("FAIL latchclip_addr f=%0d i=%0d got=%0d exp=%0d", f, i, pixel_addr, pa[i]); n_fail++;
               end
            end
         end
         if (f == 0) xpos = 12'd300;
      end
   endtask

   task automatic test_random();
      int x, y;
      for (int f = 0; f < 6; f++) begin
         x = int'($urandom_range(0, 900));
         y = int'($urandom_range(0, 600));
         latch(x, y, $urandom_range(0, 4) != 0, 1'($urandom), 1'($urandom));
         for (int i = 0; i < 60 + L; i++) begin
            if (i < 60)
               set_in(x - 5 + int'($urandom_range(0, 110)), y - 3 + int'($urandom_range(0, 140)),
                      $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0, 12'($urandom));
            else
               set_in(0, 0, 1'b1, 1'b0, 12'h000);
            step();
            n_tests++;
            if (obs() !== exp_obs) begin
               $display("FAIL random_out f=%0d i=%0d got=%h exp=%h", f, i, obs(), exp_obs); n_fail++;
            end
            n_tests++;
            if (pixel_addr !== exp_addr) begin
               $display("FAIL random_addr f=%0d i=%0d got=%0d exp=%0d", f, i, pixel_addr, exp_addr); n_fail++;
            end
         end
      end
   endtask

   initial begin
      for (int a = 0; a < 4096; a++) rom_mem[a] = 12'(a);
      rom_mem[5] = KEY;
      model_reset();
      test_reset();
      test_disabled();
      test_placement();
      test_transparency_mirror();
      test_scale2x();
      test_frame_latch_clip();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
